// File: rtl/spi_multi_serializer.sv
// SPI-style serializer that shifts SHIFT_N bits of a parallel word out on sdo/sclk,
// then raises the selected channel's latch enable for one SCLK half-period.
module spi_multi_serializer #(
  parameter int DATA_W  = 32,
  parameter int SHIFT_N = 24,
  parameter int NUM_CS  = 4,
  parameter int SEL_W   = 2,
  parameter int CLK_DIV = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]  cs_sel,
  input  logic              lsb_first,
  input  logic              cpol,
  input  logic              ld,
  output logic              busy,
  output logic              done,
  output logic              drop,
  output logic              sdo,
  output logic              sclk,
  output logic [NUM_CS-1:0] le
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(SHIFT_N + 1);
  localparam logic [SEL_W:0] NUM_CS_V = (SEL_W + 1)'(NUM_CS);

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  typedef struct packed {
    logic [SHIFT_N-1:0] sr;
    logic [SEL_W-1:0]   sel;
    logic               lsb;
    logic               cpol;
  } xfer_t;

  state_t             state_q, state_d;
  xfer_t              cur;
  logic [DIV_W-1:0]   div_cnt;
  logic [CNT_W-1:0]   bit_cnt;
  logic               phase;
  logic               done_q;
  logic               sel_ok, div_end, last_bit, accept;
  logic               unused_data;

  // Bits above SHIFT_N-1 are never transmitted.
  assign unused_data = ^{1'b0, data_in};

  assign sel_ok   = ({1'b0, cs_sel} < NUM_CS_V);
  assign div_end  = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign last_bit = (bit_cnt == CNT_W'(SHIFT_N - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE:  if (ld && sel_ok) begin
               state_d = SHIFT;
               accept  = 1'b1;
             end
      SHIFT: if (div_end && phase && last_bit) state_d = LATCH;
      LATCH: if (div_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One divider drives both SCLK half-periods (phase) and the latch window.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= '0;
      div_cnt <= '0;
      bit_cnt <= '0;
      phase   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state_q == LATCH) && div_end;
      case (state_q)
        IDLE: if (accept) begin
          cur     <= '{sr: data_in[SHIFT_N-1:0], sel: cs_sel, lsb: lsb_first, cpol: cpol};
          div_cnt <= '0;
          bit_cnt <= '0;
          phase   <= 1'b0;
        end
        SHIFT: if (div_end) begin
          div_cnt <= '0;
          phase   <= ~phase;
          if (phase) begin
            bit_cnt <= bit_cnt + 1'b1;
            cur.sr  <= cur.lsb ? (cur.sr >> 1) : (cur.sr << 1);
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
        LATCH: div_cnt <= div_end ? '0 : div_cnt + 1'b1;
        default: div_cnt <= '0;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = done_q;
    drop = ld && !rst && (busy || !sel_ok);
    sclk = cur.cpol ^ ((state_q == SHIFT) && phase);
    sdo  = 1'b0;
    le   = '0;
    if (state_q == SHIFT) sdo = cur.lsb ? cur.sr[0] : cur.sr[SHIFT_N-1];
    if (state_q == LATCH) le = NUM_CS'(1) << cur.sel;
  end

endmodule

// File: tb/tb_spi_multi_serializer.sv
// Directed bench for spi_multi_serializer: 24-bit shifts, CLK_DIV=4, three channels.
module tb_spi_multi_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [1:0]  cs_sel;
  logic        lsb_first, cpol, ld;
  logic        busy, done, drop, sdo, sclk;
  logic [2:0]  le;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_multi_serializer #(
    .DATA_W(32), .SHIFT_N(24), .NUM_CS(3), .SEL_W(2), .CLK_DIV(4)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .cs_sel(cs_sel),
    .lsb_first(lsb_first), .cpol(cpol), .ld(ld), .busy(busy),
    .done(done), .drop(drop), .sdo(sdo), .sclk(sclk), .le(le)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Optionally launch a transfer, then watch it cycle by cycle until done.
  task automatic xfer(input logic [31:0] d, input logic [1:0] sel, input logic lsb,
                      input logic pol, input bit launch, input bit hold,
                      input int extra_at, input logic [23:0] exp_rx, input string tag);
    logic [23:0] rx = '0;
    int edges = 0, le_hit = 0, le_other = 0, done_at = -1, drops = 0;
    logic prev;
    if (launch) begin
      @(negedge clk);
      data_in = d; cs_sel = sel; lsb_first = lsb; cpol = pol; ld = 1'b1;
      #1 chk({tag, " drop@accept"}, drop, 0);
    end
    prev = sclk;
    for (int c = 1; c <= 400 && done_at < 0; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) ld = 1'b0;
      if (c == extra_at) ld = 1'b1;
      else if (c == extra_at + 1) ld = 1'b0;
      #1;
      if (c == 1) chk({tag, " busy@1"}, busy, 1);
      if (c == extra_at) chk({tag, " drop@extra"}, drop, 1);
      if (drop) drops++;
      if (sclk != prev && sclk == !pol) begin
        rx = {rx[22:0], sdo};
        edges++;
      end
      prev = sclk;
      for (int i = 0; i < 3; i++)
        if (le[i]) begin
          if (i == int'(sel)) le_hit++;
          else le_other++;
        end
      if (done) begin
        done_at = c;
        chk({tag, " busy@done"}, busy, 0);
      end
    end
    chk({tag, " bits"}, rx, exp_rx);
    chk({tag, " edges"}, edges, 24);
    chk({tag, " le_sel"}, le_hit, 4);
    chk({tag, " le_other"}, le_other, 0);
    chk({tag, " done_cycle"}, done_at, 197);
    if (hold) chk({tag, " drops"}, drops, 196);
  endtask

  initial begin
    int le_seen, done_seen, busy_seen;
    rst = 1'b1; ld = 1'b0; data_in = '0; cs_sel = '0; lsb_first = 1'b0; cpol = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst drop", drop, 0);
    chk("rst sdo", sdo, 0);
    chk("rst sclk", sclk, 0);
    chk("rst le", le, 0);
    rst = 1'b0;

    xfer(32'h00A5C3F0, 2'd2, 1'b0, 1'b0, 1, 0, -1, 24'hA5C3F0, "msb");
    #1 chk("idle sclk0", sclk, 0);
    chk("idle sdo", sdo, 0);

    xfer(32'h00000001, 2'd0, 1'b1, 1'b1, 1, 0, -1, 24'h800000, "lsb_cpol1");
    #1 chk("idle sclk1", sclk, 1);

    // Out-of-range channel is rejected without disturbing idle outputs.
    @(negedge clk);
    cs_sel = 2'd3; ld = 1'b1;
    #1 chk("sel3 drop", drop, 1);
    @(negedge clk);
    ld = 1'b0;
    #1 chk("sel3 busy", busy, 0);
    chk("sel3 drop_clr", drop, 0);
    chk("sel3 sclk", sclk, 1);
    chk("sel3 le", le, 0);

    xfer(32'hFF123456, 2'd1, 1'b0, 1'b0, 1, 0, 50, 24'h123456, "extra_ld");
    xfer(32'h00A5C3F0, 2'd1, 1'b1, 1'b0, 1, 0, -1, 24'h0FC3A5, "lsb_rev");

    // Abort during bit 10 (cycles 81..88).
    @(negedge clk);
    data_in = 32'h00FFFFFF; cs_sel = 2'd0; lsb_first = 1'b0; cpol = 1'b1; ld = 1'b1;
    for (int c = 1; c <= 85; c++) begin
      @(negedge clk);
      if (c == 1) ld = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sdo", sdo, 0);
    chk("abort sclk", sclk, 0);
    chk("abort le", le, 0);
    le_seen = 0; done_seen = 0; busy_seen = 0;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      #1;
      if (le != 0) le_seen++;
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    chk("abort no_le", le_seen, 0);
    chk("abort no_done", done_seen, 0);
    chk("abort no_busy", busy_seen, 0);
    xfer(32'h00A5C3F0, 2'd2, 1'b0, 1'b0, 1, 0, -1, 24'hA5C3F0, "post_abort");

    // ld held across done: back-to-back transfers with one idle cycle.
    xfer(32'h00C0FFEE, 2'd1, 1'b0, 1'b0, 1, 1, -1, 24'hC0FFEE, "hold1");
    xfer(32'h00C0FFEE, 2'd1, 1'b0, 1'b0, 0, 0, -1, 24'hC0FFEE, "hold2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_multi_serializer.md
SPI_MULTI_SERIALIZER -- requirements
Module: spi_multi_serializer

Interface
REQ-001 Parameter: DATA_W, 32, width of the parallel load word.
REQ-002 Parameter: SHIFT_N, 24, bits shifted per transfer, 1 <= SHIFT_N <= DATA_W.
REQ-003 Parameter: NUM_CS, 4, number of latch-enable channels, >= 1.
REQ-004 Parameter: SEL_W, 2, width of cs_sel, 2**SEL_W >= NUM_CS.
REQ-005 Parameter: CLK_DIV, 20, clk cycles per SCLK half-period, >= 2.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous and active-high.
REQ-008 data_in  in  DATA_W  word to transmit.
REQ-009 cs_sel  in  SEL_W  target channel index.
REQ-010 lsb_first  in  1  1 = LSB first, 0 = MSB first.
REQ-011 cpol  in  1  SCLK idle level for this transfer.
REQ-012 ld  in  1  start request; level-sampled.
REQ-013 busy  out  1  transfer in progress.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 drop  out  1  one-cycle pulse: request rejected.
REQ-016 sdo  out  1  serial data.
REQ-017 sclk  out  1  serial clock.
REQ-018 le  out  NUM_CS  per-channel active-high latch enable.

Function
REQ-019 No derived or gated clocks; SCLK timing SHALL come from a single divider counter in the clk domain.
REQ-020 States: IDLE, SHIFT, LATCH; no other reachable states.
REQ-021 IDLE: ld=1 with cs_sel < NUM_CS SHALL capture data_in, cs_sel, lsb_first, cpol; enter SHIFT; busy=1 from the next cycle; divider and bit counters cleared.
REQ-022 IDLE: ld=1 with cs_sel >= NUM_CS SHALL pulse drop for one cycle and remain in IDLE.
REQ-023 ld=1 while busy=1 SHALL pulse drop each such cycle and not affect the transfer in progress.
REQ-024 sdo SHALL present bit k from the first SHIFT cycle of bit k; MSB-first sequence data[SHIFT_N-1]..data[0], LSB-first data[0]..data[SHIFT_N-1]; bits above SHIFT_N-1 never sent.
REQ-025 Each bit SHALL last 2*CLK_DIV cycles: sclk at captured idle level for CLK_DIV cycles, then inverted for CLK_DIV cycles (leading edge = sample edge).
REQ-026 After SHIFT_N bits: enter LATCH, sclk at idle level, le[sel]=1 for exactly CLK_DIV cycles; all other le bits 0 throughout.
REQ-027 Cycle after LATCH: done=1, busy=0, state IDLE; ld sampled in that cycle per REQ-021/022.
REQ-028 Latency: accept at cycle 0 -> done at cycle 1 + 2*SHIFT_N*CLK_DIV + CLK_DIV.
REQ-029 In IDLE: sclk held at last captured cpol, sdo=0, le=0.
REQ-030 Counters SHALL be sized to hold CLK_DIV-1 and SHIFT_N without wrap; no counter wraps mid-transfer.

Reset
REQ-031 rst=1 SHALL on the next clk edge set state IDLE, busy=0, done=0, drop=0, sdo=0, sclk=0, le=0, captured cpol=0, counters 0.
REQ-032 rst mid-transfer SHALL abort without any le or done pulse; rst has priority over ld.

Verification (DATA_W=32, SHIFT_N=24, NUM_CS=3, SEL_W=2, CLK_DIV=4)
REQ-033 ld 1 cycle, data 0x00A5C3F0, sel 2, MSB-first, cpol 0 -> 24 rising sclk edges sampling 0xA5C3F0 MSB-first; le[2] high 4 cycles; done at cycle 197; le[1:0]=0.
REQ-034 data 0x00000001, sel 0, LSB-first, cpol 1 -> sclk idles high, 24 falling edges, first sampled bit 1 then 23 zeros; le[0] pulses.
REQ-035 ld pulsed at cycle 50 of a transfer -> drop=1 that cycle; shifted bits and done cycle unchanged.
REQ-036 sel 3 in IDLE -> drop 1 cycle, busy stays 0, sclk/le unchanged.
REQ-037 rst at bit 10 -> next cycle all outputs at reset values, no le/done; subsequent ld completes normally.
REQ-038 ld held high across done -> second transfer accepted at done cycle; busy low exactly 1 cycle between transfers.
